// File: rtl/ins_commit_pkg.sv
// ins_commit_pkg: shared types and defaults for the commit/writeback stage.
// FSM encoding, fault codes and the captured request bundle.
package ins_commit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REG  = 2'd1,
    ST_MEM  = 2'd2,
    ST_PC   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE        = 2'd0,
    FAULT_PC_MISALIGN = 2'd1,
    FAULT_BUS_TIMEOUT = 2'd2
  } fault_t;

  localparam logic [31:0] PC_STEP_DEF = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  reg_idx;
    logic [31:0] reg_val;
    logic        mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_val;
    logic        pc_op;
    logic [31:0] pc_val;
  } commit_req_t;

  function automatic logic pc_misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ins_commit_if.sv
// ins_commit_if: executor handshake, register file, data bus and PC ports
// of the commit stage. slave = the stage, master = its environment.
interface ins_commit_if;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] reg_pc_val;
  logic        reg_w_op;
  logic [4:0]  reg_w_reg_idx;
  logic [31:0] reg_w_reg_val;
  logic        mem_w_op;
  logic [31:0] mem_w_mem_addr;
  logic [31:0] mem_w_mem_val;
  logic        reg_pc_w_op;
  logic [31:0] reg_pc_w_val;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_bus_req;
  logic [31:0] mem_bus_addr;
  logic [31:0] mem_bus_wdata;
  logic        mem_bus_ack;
  logic        pc_we;
  logic [31:0] pc_wval;
  logic        commit_done;
  logic        commit_fault;
  logic [1:0]  fault_cause;

  modport master (
    output commit_valid, reg_pc_val,
    output reg_w_op, reg_w_reg_idx, reg_w_reg_val,
    output mem_w_op, mem_w_mem_addr, mem_w_mem_val,
    output reg_pc_w_op, reg_pc_w_val, mem_bus_ack,
    input  commit_ready, rf_we, rf_waddr, rf_wdata,
    input  mem_bus_req, mem_bus_addr, mem_bus_wdata,
    input  pc_we, pc_wval,
    input  commit_done, commit_fault, fault_cause
  );

  modport slave (
    input  commit_valid, reg_pc_val,
    input  reg_w_op, reg_w_reg_idx, reg_w_reg_val,
    input  mem_w_op, mem_w_mem_addr, mem_w_mem_val,
    input  reg_pc_w_op, reg_pc_w_val, mem_bus_ack,
    output commit_ready, rf_we, rf_waddr, rf_wdata,
    output mem_bus_req, mem_bus_addr, mem_bus_wdata,
    output pc_we, pc_wval,
    output commit_done, commit_fault, fault_cause
  );
endinterface

// File: rtl/ins_commit_mem_port.sv
// ins_commit_mem_port: data bus write port with req/ack hold and timeout.
// o_timeout pulses the cycle after req is dropped for lack of ack.
module ins_commit_mem_port #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_ack,
  output logic        o_req,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  output logic        o_done,
  output logic        o_timeout
);

  localparam logic [7:0] LP_LAST = 8'(MEM_TIMEOUT - 1);

  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [7:0]  r_cnt;
  logic        r_to;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= '0;
      r_to   <= 1'b0;
    end else begin
      r_to <= 1'b0;
      if (i_start) begin
        r_req  <= 1'b1;
        r_addr <= i_addr;
        r_data <= i_data;
        r_cnt  <= '0;
      end else if (r_req) begin
        if (i_ack) begin
          r_req <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
          // last waiting cycle: ack still wins if it arrives now
          if (r_cnt == LP_LAST) begin
            r_req <= 1'b0;
            r_to  <= 1'b1;
          end
        end
      end
    end
  end

  assign o_req     = r_req;
  assign o_addr    = r_addr;
  assign o_data    = r_data;
  assign o_done    = r_req & i_ack;
  assign o_timeout = r_to;

endmodule

// File: rtl/ins_commit.sv
// ins_commit: commit/writeback stage applying register, memory and PC
// writes of one executed instruction in fixed order.
module ins_commit
  import ins_commit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [31:0] PC_STEP     = PC_STEP_DEF
) (
  input logic         sys_clk,
  input logic         sys_rst_n,
  ins_commit_if.slave cif
);

  state_t      r_state;
  state_t      w_state_nxt;
  commit_req_t r_cap;
  fault_t      r_cause;
  fault_t      w_cause_nxt;

  logic        r_rf_we;
  logic        r_pc_we;
  logic [31:0] r_pc_wval;
  logic        r_done;
  logic        r_fault;

  logic        w_accept;
  logic        w_start;
  logic        w_mem_done;
  logic        w_mem_to;
  logic        w_to_pc;
  logic        w_mis;
  logic        w_rf_we_nxt;
  logic        w_pc_we_nxt;
  logic [31:0] w_pc_wval_nxt;

  assign w_accept = (r_state == ST_IDLE) & cif.commit_valid;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (cif.commit_valid) w_state_nxt = ST_REG;
      ST_REG:  w_state_nxt = r_cap.mem_op ? ST_MEM : ST_PC;
      ST_MEM:  if (w_mem_done | w_mem_to) w_state_nxt = ST_PC;
      ST_PC:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start       = 1'b0;
    w_to_pc       = 1'b0;
    w_cause_nxt   = r_cause;
    w_mis         = r_cap.pc_op & pc_misaligned(r_cap.pc_val);
    w_rf_we_nxt   = w_accept & cif.reg_w_op &
                    (cif.reg_w_reg_idx != 5'd0);
    w_pc_wval_nxt = r_cap.pc_op ? r_cap.pc_val
                                : r_cap.pc + PC_STEP;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        if (w_accept) w_cause_nxt = FAULT_NONE;
      end
      (r_state == ST_REG): begin
        w_start = r_cap.mem_op;
        w_to_pc = ~r_cap.mem_op;
      end
      (r_state == ST_MEM): begin
        w_to_pc = w_mem_done | w_mem_to;
        if (w_mem_to) w_cause_nxt = FAULT_BUS_TIMEOUT;
      end
      default: ;
    endcase
    // the PC step runs last, so its cause overrides a bus timeout
    if (w_to_pc & w_mis) w_cause_nxt = FAULT_PC_MISALIGN;
    w_pc_we_nxt = w_to_pc & ~w_mis;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cap     <= '0;
      r_cause   <= FAULT_NONE;
      r_rf_we   <= 1'b0;
      r_pc_we   <= 1'b0;
      r_pc_wval <= '0;
      r_done    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cap <= '{
          pc:       cif.reg_pc_val,
          reg_idx:  cif.reg_w_reg_idx,
          reg_val:  cif.reg_w_reg_val,
          mem_op:   cif.mem_w_op,
          mem_addr: cif.mem_w_mem_addr,
          mem_val:  cif.mem_w_mem_val,
          pc_op:    cif.reg_pc_w_op,
          pc_val:   cif.reg_pc_w_val
        };
      end
      if (w_to_pc) r_pc_wval <= w_pc_wval_nxt;
      r_rf_we <= w_rf_we_nxt;
      r_pc_we <= w_pc_we_nxt;
      r_done  <= w_to_pc;
      r_fault <= w_to_pc & (w_cause_nxt != FAULT_NONE);
      r_cause <= w_cause_nxt;
    end
  end

  ins_commit_mem_port #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_start  (w_start),
    .i_addr   (r_cap.mem_addr),
    .i_data   (r_cap.mem_val),
    .i_ack    (cif.mem_bus_ack),
    .o_req    (cif.mem_bus_req),
    .o_addr   (cif.mem_bus_addr),
    .o_data   (cif.mem_bus_wdata),
    .o_done   (w_mem_done),
    .o_timeout(w_mem_to)
  );

  assign cif.commit_ready = (r_state == ST_IDLE);
  assign cif.rf_we        = r_rf_we;
  assign cif.rf_waddr     = r_cap.reg_idx;
  assign cif.rf_wdata     = r_cap.reg_val;
  assign cif.pc_we        = r_pc_we;
  assign cif.pc_wval      = r_pc_wval;
  assign cif.commit_done  = r_done;
  assign cif.commit_fault = r_fault;
  assign cif.fault_cause  = r_cause;

endmodule
